traffic_phase_ctrl: RTL and testbench

Parametrised four-approach traffic-light sequencer: main road (M1, M2), main turn lane (MT) and side road (S). Phase durations are parameters counted in ticks from an internal clock prescaler. Adds all-red clearance, a flashing-yellow fallback and an optional latched pedestrian phase. Drives the lamp outputs directly from the top level.

---
 rtl/traffic_phase_ctrl.sv | 177 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: four-approach traffic-light sequencer (M1, M2, MT, S).
// Phases are timed in ticks from a free-running prescaler. The cycle includes
// all-red clearance and a flashing-yellow fallback entered from the all-red
// phases. The latched pedestrian phase is built only when PED_PHASE_EN is
// defined; without it, ped_req is ignored and ped_walk stays low.
module traffic_phase_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAIN_T   = 7,
  parameter int unsigned YEL_T    = 2,
  parameter int unsigned TURN_T   = 5,
  parameter int unsigned SIDE_T   = 3,
  parameter int unsigned CLEAR_T  = 1,
  parameter int unsigned PED_T    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_req,
  input  logic       ped_req,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       ped_walk,
  output logic [3:0] phase
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_DUR = max2(max2(max2(MAIN_T, YEL_T), max2(TURN_T, SIDE_T)),
                                         max2(CLEAR_T, PED_T));
  localparam int unsigned TW = $clog2(MAX_DUR + 1);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [3:0] {
    ST_ALLRED_M = 4'd0,
    ST_MAIN_GO  = 4'd1,
    ST_M2_YEL   = 4'd2,
    ST_TURN_GO  = 4'd3,
    ST_TURN_YEL = 4'd4,
    ST_ALLRED_S = 4'd5,
    ST_SIDE_GO  = 4'd6,
    ST_SIDE_YEL = 4'd7,
    ST_ALLRED_P = 4'd8,
    ST_PED_WALK = 4'd9,
    ST_FLASH    = 4'd10
  } state_t;

  // The state register is a raw 4-bit vector so that the unused codes are
  // representable and can be recovered from.
  logic [3:0]    state_q;
  state_t        state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] dur_last;
  logic [PW-1:0] pre_q;
  logic          tick;
  logic          phase_end;
  logic          blink_q;

  assign tick      = (pre_q == PW'(TICK_DIV - 1));
  assign phase_end = tick && (timer_q == dur_last);

  // Free-running prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst || tick) pre_q <= '0;
    else             pre_q <= pre_q + PW'(1);
  end

`ifdef PED_PHASE_EN
  logic ped_pending_q;

  // Sticky pedestrian request; a new request wins over the clear on entry to walk.
  always_ff @(posedge clk) begin
    if (rst)                                                  ped_pending_q <= 1'b0;
    else if (ped_req)                                         ped_pending_q <= 1'b1;
    else if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) ped_pending_q <= 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // Last timer value of the current phase.
  always_comb begin
    dur_last = '0;
    case (state_q)
      ST_ALLRED_M, ST_ALLRED_S:             dur_last = TW'(CLEAR_T - 1);
      ST_MAIN_GO:                           dur_last = TW'(MAIN_T - 1);
      ST_M2_YEL, ST_TURN_YEL, ST_SIDE_YEL:  dur_last = TW'(YEL_T - 1);
      ST_TURN_GO:                           dur_last = TW'(TURN_T - 1);
      ST_SIDE_GO:                           dur_last = TW'(SIDE_T - 1);
`ifdef PED_PHASE_EN
      ST_ALLRED_P:                          dur_last = TW'(CLEAR_T - 1);
      ST_PED_WALK:                          dur_last = TW'(PED_T - 1);
`endif
      default:                              dur_last = '0;
    endcase
  end

  // Next-state selection; flash is only considered at the ends of the all-red phases.
  always_comb begin
    state_d = ST_ALLRED_M;
    case (state_q)
      ST_ALLRED_M: state_d = phase_end ? (flash_req ? ST_FLASH : ST_MAIN_GO) : ST_ALLRED_M;
      ST_MAIN_GO:  state_d = phase_end ? ST_M2_YEL   : ST_MAIN_GO;
      ST_M2_YEL:   state_d = phase_end ? ST_TURN_GO  : ST_M2_YEL;
      ST_TURN_GO:  state_d = phase_end ? ST_TURN_YEL : ST_TURN_GO;
      ST_TURN_YEL: state_d = phase_end ? ST_ALLRED_S : ST_TURN_YEL;
      ST_ALLRED_S: state_d = phase_end ? (flash_req ? ST_FLASH : ST_SIDE_GO) : ST_ALLRED_S;
      ST_SIDE_GO:  state_d = phase_end ? ST_SIDE_YEL : ST_SIDE_GO;
`ifdef PED_PHASE_EN
      ST_SIDE_YEL: state_d = phase_end ? (ped_pending_q ? ST_ALLRED_P : ST_ALLRED_M) : ST_SIDE_YEL;
      ST_ALLRED_P: state_d = phase_end ? ST_PED_WALK : ST_ALLRED_P;
      ST_PED_WALK: state_d = phase_end ? ST_ALLRED_M : ST_PED_WALK;
`else
      ST_SIDE_YEL: state_d = phase_end ? ST_ALLRED_M : ST_SIDE_YEL;
`endif
      ST_FLASH:    state_d = (tick && !flash_req) ? ST_ALLRED_M : ST_FLASH;
      default:     state_d = ST_ALLRED_M;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ALLRED_M;
    else     state_q <= state_d;
  end

  // Phase timer: restarts on every state change, otherwise counts ticks.
  always_ff @(posedge clk) begin
    if (rst)                                 timer_q <= '0;
    else if (state_d != state_q)             timer_q <= '0;
    else if (tick && state_q != ST_FLASH)    timer_q <= timer_q + TW'(1);
  end

  // Flash beat: lit on entry to FLASH, toggled on every tick while flashing.
  always_ff @(posedge clk) begin
    if (rst)                                             blink_q <= 1'b0;
    else if (state_q != ST_FLASH && state_d == ST_FLASH) blink_q <= 1'b1;
    else if (state_q == ST_FLASH && tick)                blink_q <= ~blink_q;
  end

  // Lamp decode from registered state only.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    ped_walk = 1'b0;
    case (state_q)
      ST_MAIN_GO:  begin light_M1 = GRN; light_M2 = GRN; end
      ST_M2_YEL:   begin light_M1 = GRN; light_M2 = YEL; end
      ST_TURN_GO:  begin light_M1 = GRN; light_MT = GRN; end
      ST_TURN_YEL: begin light_M1 = YEL; light_MT = YEL; end
      ST_SIDE_GO:  light_S = GRN;
      ST_SIDE_YEL: light_S = YEL;
`ifdef PED_PHASE_EN
      ST_PED_WALK: ped_walk = 1'b1;
`endif
      ST_FLASH: begin
        light_M1 = {1'b0, blink_q, 1'b0};
        light_M2 = {1'b0, blink_q, 1'b0};
        light_MT = {1'b0, blink_q, 1'b0};
        light_S  = {1'b0, blink_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a cycle-level model computes the expected
// phase and lamps from the phase table and tick arithmetic; a fixed table of
// hand-computed (scenario, cycle, phase, lamps) points pins the model.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  localparam int TD = 4, MT = 5, YT = 2, TT = 3, ST = 4, CT = 1, PT = 3;
`ifdef PED_PHASE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flash_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       ped_walk;
  logic [3:0] phase;

  traffic_phase_ctrl #(
    .TICK_DIV(TD), .MAIN_T(MT), .YEL_T(YT), .TURN_T(TT),
    .SIDE_T(ST), .CLEAR_T(CT), .PED_T(PT)
  ) dut (
    .clk(clk), .rst(rst), .flash_req(flash_req), .ped_req(ped_req),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // Packed lamp words {M1, M2, MT, S}
  localparam logic [11:0] LR = 12'b100_100_100_100;
  localparam logic [11:0] L1 = 12'b001_001_100_100;
  localparam logic [11:0] L2 = 12'b001_010_100_100;
  localparam logic [11:0] L3 = 12'b001_100_001_100;
  localparam logic [11:0] L4 = 12'b010_100_010_100;
  localparam logic [11:0] L6 = 12'b100_100_100_001;
  localparam logic [11:0] L7 = 12'b100_100_100_010;
  localparam logic [11:0] LY = 12'b010_010_010_010;
  localparam logic [11:0] LO = 12'b000_000_000_000;

  localparam int NL = 34;
  int lit_scen[NL] = '{1,1,1,1,1,1,1,1,1,1,1,1,
                       2,2,2,2,2,2,2,2,
                       3,3,3,3,3,3,3,3,
                       6,6,
                       4,4,4,4};
  int lit_cyc[NL]  = '{3,4,23,24,32,44,52,56,72,79,80,84,
                       55,56,59,60,64,71,72,76,
                       79,80,84,95,96,100,175,176,
                       80,84,
                       35,0,3,4};
  int lit_ph[NL]   = '{0,1,1,2,3,4,5,6,7,7,0,1,
                       5,10,10,10,10,10,0,1,
                       7,8,9,9,0,1,7,0,
                       0,1,
                       3,0,0,1};
  logic [11:0] lit_lamp[NL] = '{LR,L1,L1,L2,L3,L4,LR,L6,L7,L7,LR,L1,
                                LR,LY,LY,LO,LY,LO,LR,L1,
                                L7,LR,LR,LR,LR,L1,L7,LR,
                                LR,L1,
                                L3,LR,LR,L1};

  int n_pass = 0;
  int n_tot  = 0;
  int scen   = 0;
  bit inj    = 1'b0;

  // Behavioural model state
  int m_pre, m_ph, m_left, m_cyc;
  bit m_blink, m_pend, m_valid = 1'b0, m_after_ill = 1'b0;

  function automatic int dur(input int ph);
    case (ph)
      0, 5, 8: return CT;
      1:       return MT;
      2, 4, 7: return YT;
      3:       return TT;
      6:       return ST;
      9:       return PT;
      default: return 1;
    endcase
  endfunction

  function automatic int next_ph(input int ph, input bit fl, input bit pend);
    case (ph)
      0:       return fl ? 10 : 1;
      5:       return fl ? 10 : 6;
      7:       return pend ? 8 : 0;
      9:       return 0;
      default: return ph + 1;
    endcase
  endfunction

  function automatic logic [11:0] exp_lamps(input int ph, input bit bl);
    case (ph)
      1:  return L1;
      2:  return L2;
      3:  return L3;
      4:  return L4;
      6:  return L6;
      7:  return L7;
      10: return bl ? LY : LO;
      default: return LR;
    endcase
  endfunction

  // Model advances on every rising edge with the same inputs the DUT sees.
  always @(posedge clk) begin : model
    bit tk;
    int nx;
    m_after_ill = 1'b0;
    if (rst) begin
      m_pre = 0; m_ph = 0; m_left = dur(0); m_blink = 1'b0; m_pend = 1'b0;
      m_cyc = 0; m_valid = 1'b1;
    end else begin
      m_cyc++;
      tk = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (inj) begin
        m_ph = 0; m_left = dur(0); m_after_ill = 1'b1;
      end else if (m_ph == 10) begin
        if (tk) begin
          if (!flash_req) begin m_ph = 0; m_left = dur(0); end
          else m_blink = !m_blink;
        end
      end else if (tk) begin
        m_left--;
        if (m_left == 0) begin
          nx = next_ph(m_ph, flash_req, m_pend);
          if (nx == 10) m_blink = 1'b1;
          if (nx == 9)  m_pend = 1'b0;
          m_ph = nx; m_left = dur(nx);
        end
      end
      if (PED_EN && ped_req) m_pend = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (scen %0d cyc %0d)", name, act, exp, scen, m_cyc);
  endtask

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("phase", 32'(phase), 32'(m_ph));
      chk("lamps", 32'({light_M1, light_M2, light_MT, light_S}), 32'(exp_lamps(m_ph, m_blink)));
      chk("ped_walk", 32'(ped_walk), 32'(m_ph == 9));
      if (m_after_ill) chk("timer_after_illegal", 32'(dut.timer_q), 32'd0);
      for (int i = 0; i < NL; i++) begin
        if (lit_scen[i] == scen && lit_cyc[i] == m_cyc) begin
          chk("lit_phase", 32'(phase), 32'(lit_ph[i]));
          chk("lit_lamps", 32'({light_M1, light_M2, light_MT, light_S}), 32'(lit_lamp[i]));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flash_req = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Free run
    do_reset();
    scen = 1;
    repeat (170) @(negedge clk);

    // Flash entry from the side all-red phase, then exit on the next tick
    scen = 0;
    do_reset();
    scen = 2;
    repeat (10) @(negedge clk);
    flash_req = 1'b1;
    repeat (60) @(negedge clk);
    flash_req = 1'b0;
    repeat (30) @(negedge clk);

    // Single-cycle pedestrian pulse
    scen = 0;
    do_reset();
    scen = PED_EN ? 3 : 6;
    repeat (29) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    repeat (160) @(negedge clk);

    // Reset in the middle of TURN_GO
    scen = 0;
    do_reset();
    scen = 4;
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Illegal state code recovery
    scen = 0;
    do_reset();
    scen = 5;
    repeat (20) @(negedge clk);
    #1;
    dut.state_q = 4'd13;
    dut.timer_q = '1;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
